// File: rtl/channel_alt_disable.sv
// ALT disable step for one channel: inspects the channel word, takes a waiting sender's message and frees the channel.
// Latency: about 3 cycles (empty / blocked other), 4 (own registration), 6 (delivery) from enabled to finished.
// Handshake: enabled is held until finished is seen; results stay on the outputs until the next start.
module channel_alt_disable #(
  parameter int addrBits = 8,
  parameter int dataBits = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enabled,
  output logic                finished,
  output logic [addrBits-1:0] address,
  output logic                readWriteMode,
  input  logic [dataBits-1:0] dataOut,
  output logic [dataBits-1:0] dataIn,
  input  logic [addrBits-1:0] channel,
  input  logic [addrBits-1:0] rxPid,
  output logic                shouldScheduleSender,
  output logic [addrBits-1:0] scheduleTxPid,
  output logic                hasDeliveredMessage,
  output logic [dataBits-1:0] deliveredMessage,
  input  logic                rxHadMessageInAlt,
  output logic                rxHasMessageInAlt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ_WAIT = 3'd1,
    EVAL      = 3'd2,
    MSG_WAIT  = 3'd3,
    MSG_READ  = 3'd4,
    WRITE     = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [addrBits-1:0]   chan_q, chan_d;
  logic [addrBits-1:0]   pid_q, pid_d;
  logic                  had_q, had_d;
  logic [addrBits-1:0]   addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [dataBits-1:0]   din_q, din_d;
  logic                  fin_q, fin_d;
  logic                  sched_q, sched_d;
  logic [addrBits-1:0]   txpid_q, txpid_d;
  logic                  hasdel_q, hasdel_d;
  logic [dataBits-1:0]   delmsg_q, delmsg_d;
  logic                  rxhas_q, rxhas_d;

  logic [dataBits-1:0]   own_word;
  logic                  word_empty;
  logic                  word_own;

  // The channel word holds a zero-extended pid, so compare the whole word.
  assign own_word   = dataBits'(pid_q);
  assign word_empty = (dataOut == '0);
  assign word_own   = (dataOut == own_word);

  // Write enable is masked by reset so a write in flight at reset never lands in RAM.
  assign readWriteMode        = rw_q & ~reset;
  assign finished             = fin_q;
  assign address              = addr_q;
  assign dataIn               = din_q;
  assign shouldScheduleSender = sched_q;
  assign scheduleTxPid        = txpid_q;
  assign hasDeliveredMessage  = hasdel_q;
  assign deliveredMessage     = delmsg_q;
  assign rxHasMessageInAlt    = rxhas_q;

  // Next-state and next-output logic; everything holds unless a state changes it.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    pid_d    = pid_q;
    had_d    = had_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    din_d    = din_q;
    fin_d    = fin_q;
    sched_d  = sched_q;
    txpid_d  = txpid_q;
    hasdel_d = hasdel_q;
    delmsg_d = delmsg_q;
    rxhas_d  = rxhas_q;
    case (state_q)
      IDLE: begin
        rw_d  = 1'b0;
        fin_d = 1'b0;
        if (enabled) begin
          chan_d   = channel;
          pid_d    = rxPid;
          had_d    = rxHadMessageInAlt;
          sched_d  = 1'b0;
          txpid_d  = '0;
          hasdel_d = 1'b0;
          delmsg_d = '0;
          rxhas_d  = 1'b0;
          addr_d   = channel;
          state_d  = READ_WAIT;
        end
      end
      READ_WAIT: state_d = EVAL;
      EVAL: begin
        if (word_empty) begin
          fin_d   = 1'b1;
          rxhas_d = had_q;
          state_d = DONE;
        end else if (word_own) begin
          // Our own ALT registration: clear it.
          addr_d  = chan_q;
          din_d   = '0;
          rw_d    = 1'b1;
          state_d = WRITE;
        end else if (had_q) begin
          // Already received in this ALT: leave the sender blocked.
          fin_d   = 1'b1;
          rxhas_d = had_q;
          state_d = DONE;
        end else begin
          txpid_d = dataOut[addrBits-1:0];
          addr_d  = chan_q + addrBits'(1);
          state_d = MSG_WAIT;
        end
      end
      MSG_WAIT: state_d = MSG_READ;
      MSG_READ: begin
        delmsg_d = dataOut;
        hasdel_d = 1'b1;
        sched_d  = 1'b1;
        rxhas_d  = 1'b1;
        addr_d   = chan_q;
        din_d    = '0;
        rw_d     = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        rw_d    = 1'b0;
        fin_d   = 1'b1;
        rxhas_d = had_q | hasdel_q;
        state_d = DONE;
      end
      DONE: begin
        rw_d    = 1'b0;
        rxhas_d = had_q | hasdel_q;
        if (!enabled) begin
          fin_d   = 1'b0;
          state_d = IDLE;
        end else begin
          fin_d = 1'b1;
        end
      end
      default: begin
        rw_d    = 1'b0;
        fin_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      chan_q   <= '0;
      pid_q    <= '0;
      had_q    <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      din_q    <= '0;
      fin_q    <= 1'b0;
      sched_q  <= 1'b0;
      txpid_q  <= '0;
      hasdel_q <= 1'b0;
      delmsg_q <= '0;
      rxhas_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      pid_q    <= pid_d;
      had_q    <= had_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      din_q    <= din_d;
      fin_q    <= fin_d;
      sched_q  <= sched_d;
      txpid_q  <= txpid_d;
      hasdel_q <= hasdel_d;
      delmsg_q <= delmsg_d;
      rxhas_q  <= rxhas_d;
    end
  end

endmodule

// File: tb/tb_channel_alt_disable.sv
// Bench for channel_alt_disable: behavioural single-port RAM plus directed scenarios.
// Each task drives one scenario and checks results inline.
// Waits on finished are bounded; an expired bound counts as a failure.
module tb_channel_alt_disable;

  logic        clk = 1'b0;
  logic        reset;
  logic        enabled;
  logic        finished;
  logic [7:0]  address;
  logic        readWriteMode;
  logic [15:0] dataOut;
  logic [15:0] dataIn;
  logic [7:0]  channel;
  logic [7:0]  rxPid;
  logic        shouldScheduleSender;
  logic [7:0]  scheduleTxPid;
  logic        hasDeliveredMessage;
  logic [15:0] deliveredMessage;
  logic        rxHadMessageInAlt;
  logic        rxHasMessageInAlt;

  logic [15:0] ram [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_a = 8'd0;
  logic [15:0] poke_d = 16'd0;
  int          nwrites = 0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  channel_alt_disable dut (
    .clk(clk), .reset(reset), .enabled(enabled), .finished(finished),
    .address(address), .readWriteMode(readWriteMode), .dataOut(dataOut),
    .dataIn(dataIn), .channel(channel), .rxPid(rxPid),
    .shouldScheduleSender(shouldScheduleSender), .scheduleTxPid(scheduleTxPid),
    .hasDeliveredMessage(hasDeliveredMessage), .deliveredMessage(deliveredMessage),
    .rxHadMessageInAlt(rxHadMessageInAlt), .rxHasMessageInAlt(rxHasMessageInAlt)
  );

  // Synchronous-read RAM, one cycle latency; bench preloads go through poke.
  always @(posedge clk) begin
    if (poke_en) ram[poke_a] <= poke_d;
    else if (readWriteMode) begin
      ram[address] <= dataIn;
      nwrites <= nwrites + 1;
    end
    dataOut <= ram[address];
  end

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Starts one operation and waits (bounded) for finished; then drops enabled.
  task automatic run_op(input logic [7:0] ch, input logic [7:0] pid, input logic had,
                        output logic timed_out);
    @(negedge clk);
    channel = ch; rxPid = pid; rxHadMessageInAlt = had; enabled = 1'b1;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (finished) begin timed_out = 1'b0; break; end
    end
    enabled = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; enabled = 1'b0; channel = 8'd0; rxPid = 8'd0; rxHadMessageInAlt = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (finished !== 1'b0 || readWriteMode !== 1'b0) $display("FAIL reset_ctl fin=%b rw=%b need 0/0", finished, readWriteMode); else passed++;
    total++; if (address !== 8'd0 || dataIn !== 16'd0) $display("FAIL reset_bus addr=%0d din=%0d need 0/0", address, dataIn); else passed++;
    total++; if (shouldScheduleSender !== 1'b0 || scheduleTxPid !== 8'd0 || hasDeliveredMessage !== 1'b0 || deliveredMessage !== 16'd0 || rxHasMessageInAlt !== 1'b0)
      $display("FAIL reset_results sched=%b tx=%0d del=%b msg=%0d rxhas=%b need all 0", shouldScheduleSender, scheduleTxPid, hasDeliveredMessage, deliveredMessage, rxHasMessageInAlt);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_own_no_sender;
    logic to;
    poke(8'd2, 16'd7);
    run_op(8'd2, 8'd7, 1'b0, to);
    total++; if (to !== 1'b0) $display("FAIL own_finish timed_out=%b need 0", to); else passed++;
    total++; if (shouldScheduleSender !== 1'b0 || hasDeliveredMessage !== 1'b0) $display("FAIL own_flags sched=%b del=%b need 0/0", shouldScheduleSender, hasDeliveredMessage); else passed++;
    total++; if (ram[2] !== 16'd0) $display("FAIL own_ram ram2=%0d need 0", ram[2]); else passed++;
    total++; if (rxHasMessageInAlt !== 1'b0) $display("FAIL own_rxhas got=%b need 0", rxHasMessageInAlt); else passed++;
  endtask

  task automatic test_delivery;
    logic to;
    poke(8'd8, 16'd8);
    poke(8'd9, 16'd42);
    run_op(8'd8, 8'd3, 1'b0, to);
    total++; if (to !== 1'b0) $display("FAIL dlv_finish timed_out=%b need 0", to); else passed++;
    total++; if (shouldScheduleSender !== 1'b1 || scheduleTxPid !== 8'd8) $display("FAIL dlv_sched sched=%b tx=%0d need 1/8", shouldScheduleSender, scheduleTxPid); else passed++;
    total++; if (hasDeliveredMessage !== 1'b1 || deliveredMessage !== 16'd42) $display("FAIL dlv_msg del=%b msg=%0d need 1/42", hasDeliveredMessage, deliveredMessage); else passed++;
    total++; if (ram[8] !== 16'd0 || ram[9] !== 16'd42) $display("FAIL dlv_ram ram8=%0d ram9=%0d need 0/42", ram[8], ram[9]); else passed++;
    total++; if (rxHasMessageInAlt !== 1'b1) $display("FAIL dlv_rxhas got=%b need 1", rxHasMessageInAlt); else passed++;
  endtask

  task automatic test_own_had;
    logic to;
    poke(8'd10, 16'd12);
    run_op(8'd10, 8'd12, 1'b1, to);
    total++; if (to !== 1'b0) $display("FAIL ownhad_finish timed_out=%b need 0", to); else passed++;
    total++; if (shouldScheduleSender !== 1'b0 || hasDeliveredMessage !== 1'b0) $display("FAIL ownhad_flags sched=%b del=%b need 0/0", shouldScheduleSender, hasDeliveredMessage); else passed++;
    total++; if (ram[10] !== 16'd0) $display("FAIL ownhad_ram ram10=%0d need 0", ram[10]); else passed++;
    total++; if (rxHasMessageInAlt !== 1'b1) $display("FAIL ownhad_rxhas got=%b need 1", rxHasMessageInAlt); else passed++;
  endtask

  task automatic test_other_had;
    logic to;
    int w0;
    poke(8'd10, 16'd13);
    w0 = nwrites;
    run_op(8'd10, 8'd12, 1'b1, to);
    total++; if (to !== 1'b0) $display("FAIL othhad_finish timed_out=%b need 0", to); else passed++;
    total++; if (shouldScheduleSender !== 1'b0 || hasDeliveredMessage !== 1'b0) $display("FAIL othhad_flags sched=%b del=%b need 0/0", shouldScheduleSender, hasDeliveredMessage); else passed++;
    total++; if (ram[10] !== 16'd13 || nwrites != w0) $display("FAIL othhad_ram ram10=%0d writes=%0d need 13/0", ram[10], nwrites - w0); else passed++;
    total++; if (rxHasMessageInAlt !== 1'b1) $display("FAIL othhad_rxhas got=%b need 1", rxHasMessageInAlt); else passed++;
  endtask

  task automatic test_empty_and_reset;
    logic to;
    int w0;
    poke(8'd5, 16'd0);
    w0 = nwrites;
    run_op(8'd5, 8'd3, 1'b0, to);
    total++; if (to !== 1'b0) $display("FAIL empty_finish timed_out=%b need 0", to); else passed++;
    total++; if (nwrites != w0) $display("FAIL empty_writes got=%0d need 0", nwrites - w0); else passed++;
    total++; if (shouldScheduleSender !== 1'b0 || hasDeliveredMessage !== 1'b0 || rxHasMessageInAlt !== 1'b0)
      $display("FAIL empty_flags sched=%b del=%b rxhas=%b need 0/0/0", shouldScheduleSender, hasDeliveredMessage, rxHasMessageInAlt);
    else passed++;
    // Reset lands on the cycle the channel-clearing write would occur.
    poke(8'd20, 16'd6);
    poke(8'd21, 16'd77);
    @(negedge clk);
    channel = 8'd20; rxPid = 8'd1; rxHadMessageInAlt = 1'b0; enabled = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; enabled = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    total++; if (finished !== 1'b0 || readWriteMode !== 1'b0 || shouldScheduleSender !== 1'b0 || scheduleTxPid !== 8'd0 || hasDeliveredMessage !== 1'b0 || deliveredMessage !== 16'd0)
      $display("FAIL midreset_outs fin=%b rw=%b sched=%b tx=%0d del=%b msg=%0d need all 0", finished, readWriteMode, shouldScheduleSender, scheduleTxPid, hasDeliveredMessage, deliveredMessage);
    else passed++;
    repeat (3) @(negedge clk);
    total++; if (ram[20] !== 16'd6 || finished !== 1'b0) $display("FAIL midreset_ram ram20=%0d fin=%b need 6/0", ram[20], finished); else passed++;
  endtask

  task automatic test_wrap;
    logic to;
    poke(8'd255, 16'd4);
    poke(8'd0, 16'd99);
    run_op(8'd255, 8'd1, 1'b0, to);
    total++; if (to !== 1'b0) $display("FAIL wrap_finish timed_out=%b need 0", to); else passed++;
    total++; if (deliveredMessage !== 16'd99 || scheduleTxPid !== 8'd4) $display("FAIL wrap_result msg=%0d tx=%0d need 99/4", deliveredMessage, scheduleTxPid); else passed++;
    total++; if (ram[255] !== 16'd0 || ram[0] !== 16'd99) $display("FAIL wrap_ram ram255=%0d ram0=%0d need 0/99", ram[255], ram[0]); else passed++;
  endtask

  task automatic test_back_to_back;
    logic to;
    // Follows a delivery: a fresh start must clear the previous results.
    run_op(8'd5, 8'd3, 1'b0, to);
    total++; if (to !== 1'b0) $display("FAIL b2b_finish timed_out=%b need 0", to); else passed++;
    total++; if (hasDeliveredMessage !== 1'b0 || deliveredMessage !== 16'd0 || shouldScheduleSender !== 1'b0 || scheduleTxPid !== 8'd0)
      $display("FAIL b2b_cleared del=%b msg=%0d sched=%b tx=%0d need 0/0/0/0", hasDeliveredMessage, deliveredMessage, shouldScheduleSender, scheduleTxPid);
    else passed++;
  endtask

  task automatic test_early_drop;
    logic seen;
    @(negedge clk);
    channel = 8'd5; rxPid = 8'd3; rxHadMessageInAlt = 1'b1; enabled = 1'b1;
    @(negedge clk);
    enabled = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (finished) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (seen !== 1'b1 || rxHasMessageInAlt !== 1'b1) $display("FAIL early_drop_done seen=%b rxhas=%b need 1/1", seen, rxHasMessageInAlt); else passed++;
    @(negedge clk);
    total++; if (finished !== 1'b0) $display("FAIL early_drop_idle fin=%b need 0", finished); else passed++;
  endtask

  initial begin
    test_reset;
    test_own_no_sender;
    test_delivery;
    test_own_had;
    test_other_had;
    test_empty_and_reset;
    test_wrap;
    test_back_to_back;
    test_early_drop;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
